// File: rtl/eject_arb_pkg.sv
// Shared definitions for the router ejection stage: port status encoding,
// destination field placement, and slot count.
package eject_arb_pkg;

  localparam int NUM_SLOTS      = 4;
  localparam int PORT_STAT_SIZE = 2;
  localparam logic [PORT_STAT_SIZE-1:0] ACTIVE = 2'b01;

  // Destination field placement inside a flit.
  localparam int DEST_POS = 0;
  localparam int DEST_W   = 4;

  // Slot index arithmetic wraps modulo NUM_SLOTS.
  function automatic logic [1:0] slot_add(input logic [1:0] a, input logic [1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/eject_fifo.sv
// Small ejection FIFO. The head entry is kept in a register so the output
// holds its last value once the FIFO drains and reads 0 after reset.
module eject_fifo #(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [FLIT_W-1:0] din,
  input  logic              pop,
  output logic [FLIT_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head, tail, head_nxt;
  logic [AW:0]       count_nxt;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next head pointer and occupancy.
  always_comb begin
    head_nxt  = do_pop ? head + 1'b1 : head;
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  // Storage, pointers and the registered head entry. When the next head is
  // the slot being written this cycle, forward din so there is no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= din;
        tail      <= tail + 1'b1;
      end
      head  <= head_nxt;
      count <= count_nxt;
      if (count_nxt != '0)
        dout <= (do_push && head_nxt == tail) ? din : mem[head_nxt];
    end
  end

endmodule

// File: rtl/eject_arb.sv
// Ejection arbiter: claims at most one locally addressed flit per cycle from
// the four channel slots (round-robin), queues it, and hands it to the PE.
module eject_arb
  import eject_arb_pkg::*;
#(
  parameter int FLIT_W    = 64,
  parameter int NODE_ID_W = DEST_W,
  parameter int DEST_LSB  = DEST_POS,
  parameter int DEPTH     = 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NODE_ID_W-1:0]              localId,
  input  logic [NUM_SLOTS-1:0]              valid,
  input  logic [NUM_SLOTS*FLIT_W-1:0]       flitIn,
  input  logic [NUM_SLOTS*PORT_STAT_SIZE-1:0] portStatus,
  output logic [NUM_SLOTS-1:0]              ejectGrant,
  output logic [FLIT_W-1:0]                 ejFlit,
  output logic                              ejValid,
  input  logic                              ejReady,
  output logic [AW:0]                       fifoCount,
  output logic [15:0]                       ejectCount
);

  logic [NUM_SLOTS-1:0] match;
  logic [1:0]           rr_ptr, grant_idx;
  logic                 grant_any;
  logic                 fifo_full, fifo_empty;
  logic [FLIT_W-1:0]    grant_flit;

  // A slot matches when it holds a flit for this node on an active port.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      match[i] = valid[i]
              && (flitIn[i*FLIT_W + DEST_LSB +: NODE_ID_W] == localId)
              && (portStatus[i*PORT_STAT_SIZE +: PORT_STAT_SIZE] == ACTIVE);
  end

  // Round-robin pick starting at rr_ptr. Full is taken from the registered
  // count only, so a same-cycle pop never opens room for a grant.
  always_comb begin
    logic [1:0] idx;
    idx        = '0;
    ejectGrant = '0;
    grant_idx  = rr_ptr;
    grant_any  = 1'b0;
    if (!fifo_full) begin
      for (int off = 0; off < NUM_SLOTS; off++) begin
        idx = slot_add(rr_ptr, 2'(off));
        if (!grant_any && match[idx]) begin
          ejectGrant[idx] = 1'b1;
          grant_idx       = idx;
          grant_any       = 1'b1;
        end
      end
    end
  end

  assign grant_flit = flitIn[grant_idx*FLIT_W +: FLIT_W];

  // Pointer advances past the winner; statistics counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      ejectCount <= '0;
    end else if (grant_any) begin
      rr_ptr <= slot_add(grant_idx, 2'd1);
      if (ejectCount != 16'hFFFF) ejectCount <= ejectCount + 16'd1;
    end
  end

  assign ejValid = !fifo_empty;

  eject_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (grant_any),
    .din   (grant_flit),
    .pop   (ejValid && ejReady),
    .dout  (ejFlit),
    .count (fifoCount),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_eject_arb.sv
// Directed bench for eject_arb: a vector table for grant selection/masking
// plus hand-written sequences for latency, fullness, ordering and reset.
module tb_eject_arb;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   localId;
  logic [3:0]   valid;
  logic [255:0] flitIn;
  logic [7:0]   portStatus;
  logic [3:0]   ejectGrant;
  logic [63:0]  ejFlit;
  logic         ejValid;
  logic         ejReady;
  logic [2:0]   fifoCount;
  logic [15:0]  ejectCount;

  eject_arb dut (
    .clk(clk), .reset(reset), .localId(localId), .valid(valid),
    .flitIn(flitIn), .portStatus(portStatus), .ejectGrant(ejectGrant),
    .ejFlit(ejFlit), .ejValid(ejValid), .ejReady(ejReady),
    .fifoCount(fifoCount), .ejectCount(ejectCount)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] ALL_ACT = 8'b01_01_01_01;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] cur_flit [4];

  typedef struct {
    logic [3:0]  lid;
    logic [3:0]  v;
    logic [15:0] dests;   // {slot3,slot2,slot1,slot0}
    logic [7:0]  stats;   // {slot3,slot2,slot1,slot0}
    logic [3:0]  g;       // expected grant
    logic [2:0]  cnt;     // expected fifoCount after the edge
  } vec_t;

  function automatic logic [63:0] mk(input logic [7:0] tag, input logic [3:0] dest);
    return {48'hC0DE_F1A7_0000, tag, 4'h0, dest};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] dests,
                       input logic [7:0] stats, input logic [7:0] tag);
    valid = v;
    for (int i = 0; i < 4; i++) begin
      cur_flit[i] = mk(tag + 8'(i), dests[i*4 +: 4]);
      flitIn[i*64 +: 64]   = cur_flit[i];
      portStatus[i*2 +: 2] = stats[i*2 +: 2];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [8];
  logic [63:0] exp_flit, f1;
  logic [63:0] order [3];

  initial begin
    reset = 1'b1; localId = 4'd3; ejReady = 1'b0;
    drive(4'b0000, 16'h0, ALL_ACT, 8'h00);
    #1;
    chk("reset_count",  64'(fifoCount), 64'd0);
    chk("reset_valid",  64'(ejValid), 64'd0);
    chk("reset_flit",   ejFlit, 64'd0);
    chk("reset_ecount", 64'(ejectCount), 64'd0);
    step(); step();
    reset = 1'b0;

    // Single eject into an empty FIFO
    drive(4'b0100, 16'h0300, ALL_ACT, 8'h10);
    #1 chk("single_grant", 64'(ejectGrant), 64'b0100);
    exp_flit = cur_flit[2];
    step();
    chk("single_valid", 64'(ejValid), 64'd1);
    chk("single_flit",  ejFlit, exp_flit);
    chk("single_count", 64'(fifoCount), 64'd1);
    // rr pointer now 3: with all slots matching, slot 3 wins
    ejReady = 1'b1;
    drive(4'b1111, 16'h3333, ALL_ACT, 8'h18);
    #1 chk("rr_after_single", 64'(ejectGrant), 64'b1000);
    exp_flit = cur_flit[3];
    step();
    chk("pushpop_count", 64'(fifoCount), 64'd1);
    chk("pushpop_flit",  ejFlit, exp_flit);
    drive(4'b0000, 16'h0, ALL_ACT, 8'h00);
    step();
    chk("drain_valid", 64'(ejValid), 64'd0);
    chk("hold_flit",   ejFlit, exp_flit);

    // Round robin over four fully matching cycles
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 16'h3333, ALL_ACT, 8'(8'h20 + 8 * c));
      #1 chk($sformatf("rr_grant%0d", c), 64'(ejectGrant), 64'(4'b0001 << c));
      exp_flit = cur_flit[c];
      step();
      chk($sformatf("rr_flit%0d", c), ejFlit, exp_flit);
    end
    chk("rr_ecount", 64'(ejectCount), 64'd6);
    drive(4'b0000, 16'h0, ALL_ACT, 8'h00);
    step();

    // Vector table: masking and pointer rotation, ejReady held high
    vt[0] = '{4'd3, 4'b0010, 16'h0030, 8'b01_01_00_01, 4'b0000, 3'd0};
    vt[1] = '{4'd3, 4'b0001, 16'h0005, ALL_ACT,        4'b0000, 3'd0};
    vt[2] = '{4'd3, 4'b1111, 16'h3353, 8'b01_01_01_00, 4'b0100, 3'd1};
    vt[3] = '{4'd3, 4'b1111, 16'h3333, ALL_ACT,        4'b1000, 3'd1};
    vt[4] = '{4'd7, 4'b0110, 16'h0770, ALL_ACT,        4'b0010, 3'd1};
    vt[5] = '{4'd7, 4'b0011, 16'h0077, ALL_ACT,        4'b0001, 3'd1};
    vt[6] = '{4'd0, 4'b0000, 16'h0000, ALL_ACT,        4'b0000, 3'd0};
    vt[7] = '{4'd0, 4'b1001, 16'h0000, ALL_ACT,        4'b1000, 3'd1};
    for (int t = 0; t < 8; t++) begin
      localId = vt[t].lid;
      drive(vt[t].v, vt[t].dests, vt[t].stats, 8'(8'h40 + 8 * t));
      exp_flit = '0;
      for (int k = 0; k < 4; k++) if (vt[t].g[k]) exp_flit = cur_flit[k];
      #1 chk($sformatf("vec%0d_grant", t), 64'(ejectGrant), 64'(vt[t].g));
      step();
      chk($sformatf("vec%0d_count", t), 64'(fifoCount), 64'(vt[t].cnt));
      chk($sformatf("vec%0d_valid", t), 64'(ejValid), 64'(vt[t].cnt != 0));
      if (vt[t].g != 0) chk($sformatf("vec%0d_flit", t), ejFlit, exp_flit);
    end
    chk("vec_ecount", 64'(ejectCount), 64'd11);
    drive(4'b0000, 16'h0, ALL_ACT, 8'h00);
    step();

    // Full FIFO: four grants, fifth refused, pop cycle still refused
    localId = 4'd3; ejReady = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(4'b0001, 16'h0003, ALL_ACT, 8'(8'h80 + 8 * c));
      if (c == 1) f1 = cur_flit[0];
      step();
    end
    chk("full_count4", 64'(fifoCount), 64'd4);
    drive(4'b0001, 16'h0003, ALL_ACT, 8'hA0);
    #1 chk("full_no_grant", 64'(ejectGrant), 64'd0);
    step();
    chk("full_hold4", 64'(fifoCount), 64'd4);
    ejReady = 1'b1;
    #1 chk("full_pop_no_grant", 64'(ejectGrant), 64'd0);
    step();
    chk("full_pop_count", 64'(fifoCount), 64'd3);
    chk("full_pop_flit", ejFlit, f1);
    ejReady = 1'b0;
    #1 chk("full_resume", 64'(ejectGrant), 64'b0001);
    step();
    chk("full_resume_count", 64'(fifoCount), 64'd4);
    chk("full_ecount", 64'(ejectCount), 64'd16);
    drive(4'b0000, 16'h0, ALL_ACT, 8'h00);
    ejReady = 1'b1;
    repeat (4) step();
    chk("full_drained", 64'(fifoCount), 64'd0);

    // Backpressure and ordering: A, B, C then ejReady 1,0,1,1
    ejReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(4'b0001, 16'h0003, ALL_ACT, 8'(8'hB0 + 8 * c));
      order[c] = cur_flit[0];
      step();
    end
    drive(4'b0000, 16'h0, ALL_ACT, 8'h00);
    ejReady = 1'b1; #1 chk("order_0", ejFlit, order[0]); step();
    ejReady = 1'b0; #1 chk("order_1", ejFlit, order[1]); step();
    ejReady = 1'b1; #1 chk("order_2", ejFlit, order[1]); step();
    ejReady = 1'b1; #1 chk("order_3", ejFlit, order[2]); step();
    chk("order_empty", 64'(ejValid), 64'd0);
    chk("order_hold", ejFlit, order[2]);
    chk("order_ecount", 64'(ejectCount), 64'd19);

    // Reset mid-stream with fifoCount 3, ejectCount 7
    reset = 1'b1; #2 reset = 1'b0;
    #1 chk("rst_pulse_ecount", 64'(ejectCount), 64'd0);
    step();
    for (int c = 0; c < 7; c++) begin
      ejReady = (c < 5);
      drive(4'b0001, 16'h0003, ALL_ACT, 8'(8'hD0 + c));
      step();
    end
    chk("pre_rst_count",  64'(fifoCount), 64'd3);
    chk("pre_rst_ecount", 64'(ejectCount), 64'd7);
    drive(4'b0000, 16'h0, ALL_ACT, 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count",  64'(fifoCount), 64'd0);
    chk("mid_rst_valid",  64'(ejValid), 64'd0);
    chk("mid_rst_flit",   ejFlit, 64'd0);
    chk("mid_rst_ecount", 64'(ejectCount), 64'd0);
    #2 reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
